sram_copy_ctrl: RTL and testbench
=================================

Name: sram_copy_ctrl

Overview:
Wishbone-programmed sequencer that copies a block of words from a source SRAM port to a destination SRAM port in the SRAM-to-SRAM evaluation design. Software writes source address, destination address and length, then sets start. The block issues one read per cycle, aligns each write to the SRAM read latency, and raises a sticky done flag and an optional irq. It sits on the same 64-bit Wishbone bus as the other eval cores, in the clock domain of the SRAM pair.

Parameters:
WB_ADR_WIDTH, 8, Wishbone word-address width (register select uses bits [2:0]).
WB_DAT_WIDTH, 64, Wishbone data width.
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width.
SRAM_ADDR_WIDTH, 10, SRAM word-address width.
SRAM_DATA_WIDTH, 64, SRAM word width.
SRAM_READ_LATENCY, 2, cycles from src_en to valid src_rdata (≥1).
CORE_ID, 64'h527a_0000_0000_0001, value returned at register 0.

Ports:
reset  input  1  asynchronous reset, active-high
clk  input  1  single clock; all logic is in this domain
s_wb_adr_i  input  WB_ADR_WIDTH  register word address
s_wb_dat_o  output  WB_DAT_WIDTH  read data
s_wb_dat_i  input  WB_DAT_WIDTH  write data
s_wb_sel_i  input  WB_SEL_WIDTH  byte enables for writes
s_wb_we_i  input  1  write strobe
s_wb_stb_i  input  1  access strobe
s_wb_ack_o  output  1  acknowledge
src_en  output  1  source read enable
src_addr  output  SRAM_ADDR_WIDTH  source read address
src_rdata  input  SRAM_DATA_WIDTH  source read data, valid SRAM_READ_LATENCY cycles after src_en
dst_we  output  1  destination write enable
dst_addr  output  SRAM_ADDR_WIDTH  destination write address
dst_wdata  output  SRAM_DATA_WIDTH  destination write data
irq  output  1  done & irq_enable, level

Behaviour:
- Reset: all registers, FSM, pipeline and outputs = 0; src_en = 0 and dst_we = 0 immediately on reset assertion, including mid-copy. A reset during a copy abandons it with no further writes.
- Bus access: s_wb_ack_o = s_wb_stb_i (combinational; zero wait). A write is taken when stb & we, with per-byte sel. s_wb_dat_o is combinational from adr[2:0]. Unmapped addresses read 0 and ignore writes.
- Register map (adr[2:0]):
  - 0 CORE_ID: RO.
  - 1 CTL: bit0 start (W1, self-clearing, reads 0); bit1 irq_enable (RW).
  - 2 STATUS: RO; bit0 busy, bit1 done.
  - 3 DONE_CLR: writing bit0 = 1 clears done.
  - 4 SRC_ADDR.
  - 5 DST_ADDR.
  - 6 LEN: SRAM_ADDR_WIDTH+1 bits.
  - 7 COUNT: RO; words written by the current or last copy.
- Writes to SRC_ADDR, DST_ADDR and LEN while busy are ignored. A start while busy is ignored. Start clears done and COUNT.
- FSM states: IDLE, READ, DRAIN.
  - IDLE → READ on accepted start with LEN ≠ 0.
  - Start with LEN = 0: done = 1 on the next cycle, no SRAM access, busy stays 0.
  - READ: src_en = 1 every cycle; src_addr = SRC_ADDR + k for k = 0..LEN-1. → DRAIN after issuing the LEN-th read.
  - DRAIN: wait until the valid pipeline is empty, then → IDLE and set done.
  - busy = (state ≠ IDLE).
- Write alignment: a SRAM_READ_LATENCY-deep shift register carries valid + dst address. dst_we, dst_addr = DST_ADDR + k and dst_wdata = src_rdata are asserted in the cycle the data returns. dst_we and dst_addr are registered; dst_wdata is passed through from src_rdata.
- Timing: start acked at cycle T → busy = 1 and first src_en at T+1. First dst_we at T+1+L (L = SRAM_READ_LATENCY). Last dst_we at T+LEN+L. done = 1 and busy = 0 at T+LEN+L+1.
- Address arithmetic is modulo 2^SRAM_ADDR_WIDTH and wraps silently. LEN = 2^SRAM_ADDR_WIDTH copies the full memory. Overlapping source and destination ranges are not detected; the result is defined by the per-cycle order above.
- COUNT increments on each dst_we.
- Simultaneous events:
  - DONE_CLR in the same cycle done is set: set wins.
  - start and DONE_CLR written together: start wins.

Test Plan:
- SRC = 0x010, DST = 0x200, LEN = 4, src model returns addr^0xA5A5, L = 2 → dst_we pulses at 0x200..0x203 with matching data; first dst_we 3 cycles after start ack; STATUS = 0b10 and COUNT = 4 at the end.
- LEN = 0 start → done set next cycle; src_en and dst_we never asserted; busy never 1.
- SRC = 0x3FE, DST = 0x3FF, LEN = 3 (SRAM_ADDR_WIDTH = 10) → reads 0x3FE, 0x3FF, 0x000; writes 0x3FF, 0x000, 0x001.
- Mid-copy (LEN = 16): write LEN = 1, SRC = 0, then start → all ignored; copy completes 16 words. irq_enable = 1 → irq rises with done; DONE_CLR drops irq.
- Assert reset at word 5 of a 16-word copy → src_en and dst_we drop in the same cycle; after release STATUS = 0, COUNT = 0, no further writes.
- Repeat with SRAM_READ_LATENCY = 1 and 4, LEN = 8 → done at T+LEN+L+1 exactly.

Source files
------------

// File: rtl/sram_copy_ctrl.sv
// Wishbone-programmed block copy engine between a source and a destination SRAM port.
// One read is issued per cycle; writes are aligned to the source read latency by a valid/address pipeline.
module sram_copy_ctrl #(
    parameter int          WB_ADR_WIDTH      = 8,
    parameter int          WB_DAT_WIDTH      = 64,
    parameter int          WB_SEL_WIDTH      = WB_DAT_WIDTH / 8,
    parameter int          SRAM_ADDR_WIDTH   = 10,
    parameter int          SRAM_DATA_WIDTH   = 64,
    parameter int          SRAM_READ_LATENCY = 2,
    parameter logic [63:0] CORE_ID           = 64'h527a_0000_0000_0001
) (
    input  logic                       reset,
    input  logic                       clk,
    input  logic [WB_ADR_WIDTH-1:0]    s_wb_adr_i,
    output logic [WB_DAT_WIDTH-1:0]    s_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0]    s_wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]    s_wb_sel_i,
    input  logic                       s_wb_we_i,
    input  logic                       s_wb_stb_i,
    output logic                       s_wb_ack_o,
    output logic                       src_en,
    output logic [SRAM_ADDR_WIDTH-1:0] src_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] src_rdata,
    output logic                       dst_we,
    output logic [SRAM_ADDR_WIDTH-1:0] dst_addr,
    output logic [SRAM_DATA_WIDTH-1:0] dst_wdata,
    output logic                       irq
);

    localparam int AW = SRAM_ADDR_WIDTH;
    localparam int LW = SRAM_ADDR_WIDTH + 1;
    localparam int L  = SRAM_READ_LATENCY;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   src_reg;
    logic [AW-1:0]   dst_reg;
    logic [LW-1:0]   len_reg;
    logic [LW-1:0]   count_reg;
    logic [LW-1:0]   rd_idx;
    logic            irq_en;
    logic            done;

    logic            pipe_v [L];
    logic [AW-1:0]   pipe_a [L];

    logic            wr;
    logic [2:0]      reg_sel;
    logic [LW-1:0]   wmask;
    logic [LW-1:0]   src_new;
    logic [LW-1:0]   dst_new;
    logic [LW-1:0]   len_new;
    logic            start_wr;
    logic            start_acc;
    logic            done_clr;
    logic            idle;
    logic            last_rd;
    logic            pipe_empty_nxt;
    logic            unused_ok;

    assign wr         = s_wb_stb_i & s_wb_we_i;
    assign reg_sel    = s_wb_adr_i[2:0];
    assign s_wb_ack_o = s_wb_stb_i;
    assign idle       = (state == IDLE);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < LW; b++) begin
            wmask[b] = s_wb_sel_i[b / 8];
        end
    end

    function automatic logic [LW-1:0] wmerge(input logic [LW-1:0] old);
        return (old & ~wmask) | (s_wb_dat_i[LW-1:0] & wmask);
    endfunction

    assign src_new   = wmerge({1'b0, src_reg});
    assign dst_new   = wmerge({1'b0, dst_reg});
    assign len_new   = wmerge(len_reg);

    // start and DONE_CLR live in byte 0 bit 0 of their registers.
    assign start_wr  = wr && (reg_sel == 3'd1) && s_wb_sel_i[0] && s_wb_dat_i[0];
    assign done_clr  = wr && (reg_sel == 3'd3) && s_wb_sel_i[0] && s_wb_dat_i[0];
    assign start_acc = start_wr && idle;
    assign last_rd   = (rd_idx == len_reg - LW'(1));

    // Pipeline is empty after this edge when no read is issued and only the
    // output stage is currently occupied.
    always_comb begin
        pipe_empty_nxt = 1'b1;
        for (int i = 0; i < L - 1; i++) begin
            if (pipe_v[i]) pipe_empty_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc && (len_reg != '0)) state_nxt = READ;
            READ:    if (last_rd) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty_nxt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            count_reg <= '0;
            rd_idx    <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < L; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            if (wr && idle) begin
                case (reg_sel)
                    3'd4:    src_reg <= src_new[AW-1:0];
                    3'd5:    dst_reg <= dst_new[AW-1:0];
                    3'd6:    len_reg <= len_new;
                    default: ;
                endcase
            end
            if (wr && (reg_sel == 3'd1) && s_wb_sel_i[0]) irq_en <= s_wb_dat_i[1];

            if (start_acc)   rd_idx <= '0;
            else if (src_en) rd_idx <= rd_idx + LW'(1);

            pipe_v[0] <= src_en;
            pipe_a[0] <= dst_reg + rd_idx[AW-1:0];
            for (int i = 1; i < L; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end

            if (start_acc)   count_reg <= '0;
            else if (dst_we) count_reg <= count_reg + LW'(1);

            // Completion beats a same-cycle DONE_CLR; an accepted start beats DONE_CLR.
            if ((state == DRAIN) && (state_nxt == IDLE)) done <= 1'b1;
            else if (start_acc)                          done <= (len_reg == '0);
            else if (done_clr)                           done <= 1'b0;
        end
    end

    assign src_en    = (state == READ);
    assign src_addr  = src_reg + rd_idx[AW-1:0];
    assign dst_we    = pipe_v[L-1];
    assign dst_addr  = pipe_a[L-1];
    assign dst_wdata = src_rdata;
    assign irq       = done & irq_en;

    always_comb begin
        s_wb_dat_o = '0;
        case (reg_sel)
            3'd0: s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            3'd1: s_wb_dat_o[1] = irq_en;
            3'd2: s_wb_dat_o[1:0] = {done, ~idle};
            3'd4: s_wb_dat_o[AW-1:0] = src_reg;
            3'd5: s_wb_dat_o[AW-1:0] = dst_reg;
            3'd6: s_wb_dat_o[LW-1:0] = len_reg;
            3'd7: s_wb_dat_o[LW-1:0] = count_reg;
            default: ;
        endcase
    end

    assign unused_ok = ^{s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, src_new[AW], dst_new[AW]};

endmodule

// File: tb/tb_sram_copy_ctrl.sv
// Bench for sram_copy_ctrl: register table, copy sequences, wrap, reset abort,
// and completion timing at read latencies 2, 1 and 4.
module tb_sram_copy_ctrl;

    localparam logic [63:0] CORE = 64'h527a_0000_0000_0001;
    localparam int LAT [3] = '{2, 1, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  adr;
    logic [63:0] wdat;
    logic [7:0]  sel;
    logic        we;
    logic        stb       [3];
    logic [63:0] rdat      [3];
    logic        ack       [3];
    logic        src_en    [3];
    logic [9:0]  src_addr  [3];
    logic [63:0] src_rdata [3];
    logic        dst_we    [3];
    logic [9:0]  dst_addr  [3];
    logic [63:0] dst_wdata [3];
    logic        irq       [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int first_we [3];
    int last_we  [3];
    int nwe      [3];
    int nrd      [3];
    int irq_rise [3];
    logic irq_q  [3];
    logic busy_seen;

    logic [73:0] exp_q[$];
    logic [9:0]  exp_rd_q[$];
    logic [73:0] mon_e;
    logic [9:0]  mon_a;

    logic       mq_v [3][4];
    logic [9:0] mq_a [3][4];

    sram_copy_ctrl #(.SRAM_READ_LATENCY(2)) u_l2 (
        .reset(reset), .clk(clk), .s_wb_adr_i(adr), .s_wb_dat_o(rdat[0]), .s_wb_dat_i(wdat),
        .s_wb_sel_i(sel), .s_wb_we_i(we), .s_wb_stb_i(stb[0]), .s_wb_ack_o(ack[0]),
        .src_en(src_en[0]), .src_addr(src_addr[0]), .src_rdata(src_rdata[0]),
        .dst_we(dst_we[0]), .dst_addr(dst_addr[0]), .dst_wdata(dst_wdata[0]), .irq(irq[0])
    );

    sram_copy_ctrl #(.SRAM_READ_LATENCY(1)) u_l1 (
        .reset(reset), .clk(clk), .s_wb_adr_i(adr), .s_wb_dat_o(rdat[1]), .s_wb_dat_i(wdat),
        .s_wb_sel_i(sel), .s_wb_we_i(we), .s_wb_stb_i(stb[1]), .s_wb_ack_o(ack[1]),
        .src_en(src_en[1]), .src_addr(src_addr[1]), .src_rdata(src_rdata[1]),
        .dst_we(dst_we[1]), .dst_addr(dst_addr[1]), .dst_wdata(dst_wdata[1]), .irq(irq[1])
    );

    sram_copy_ctrl #(.SRAM_READ_LATENCY(4)) u_l4 (
        .reset(reset), .clk(clk), .s_wb_adr_i(adr), .s_wb_dat_o(rdat[2]), .s_wb_dat_i(wdat),
        .s_wb_sel_i(sel), .s_wb_we_i(we), .s_wb_stb_i(stb[2]), .s_wb_ack_o(ack[2]),
        .src_en(src_en[2]), .src_addr(src_addr[2]), .src_rdata(src_rdata[2]),
        .dst_we(dst_we[2]), .dst_addr(dst_addr[2]), .dst_wdata(dst_wdata[2]), .irq(irq[2])
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] fdat(input logic [9:0] a);
        return {54'd0, a} ^ 64'hA5A5;
    endfunction

    // Source SRAM model: data for a read in cycle c appears in cycle c+LAT.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mq_v[i][0] <= src_en[i];
            mq_a[i][0] <= src_addr[i];
            for (int s = 1; s < 4; s++) begin
                mq_v[i][s] <= mq_v[i][s-1];
                mq_a[i][s] <= mq_a[i][s-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            src_rdata[i] = (mq_v[i][LAT[i]-1] === 1'b1) ? fdat(mq_a[i][LAT[i]-1])
                                                         : 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dst_we[i] === 1'b1) begin
                if (first_we[i] < 0) first_we[i] = cyc;
                last_we[i] = cyc;
                nwe[i]++;
                if (i == 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {dst_addr[0], dst_wdata[0]}, 74'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("dst_write", {dst_addr[0], dst_wdata[0]}, mon_e);
                    end
                end else begin
                    check("lat_wdata", dst_wdata[i], fdat(dst_addr[i] - 10'h300 + 10'h020));
                end
            end
            if (src_en[i] === 1'b1) begin
                nrd[i]++;
                if (i == 0) begin
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_read", src_addr[0], 10'h3FF ^ src_addr[0]);
                    end else begin
                        mon_a = exp_rd_q.pop_front();
                        check("src_read", src_addr[0], mon_a);
                    end
                end
            end
            if (irq[i] && !irq_q[i]) irq_rise[i] = cyc;
            irq_q[i] = irq[i];
        end
        if (!stb[0] && adr == 8'd2 && rdat[0][0]) busy_seen = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wb_write(input int i, input logic [2:0] a, input logic [63:0] d, input logic [7:0] s);
        adr = {5'd0, a}; wdat = d; sel = s; we = 1'b1; stb[i] = 1'b1;
        tick;
        stb[i] = 1'b0; we = 1'b0; adr = 8'd2; sel = 8'h00;
    endtask

    task automatic wb_check(input int i, input logic [2:0] a, input logic [63:0] exp, input string name);
        adr = {5'd0, a}; we = 1'b0; stb[i] = 1'b1;
        #1;
        check(name, {ack[i], rdat[i]}, {1'b1, exp});
        stb[i] = 1'b0; adr = 8'd2;
        tick;
    endtask

    task automatic clear_mon(input int i);
        first_we[i] = -1; last_we[i] = -1; nwe[i] = 0; nrd[i] = 0; irq_rise[i] = -1;
        busy_seen = 1'b0;
    endtask

    task automatic setup(input int i, input logic [9:0] s, input logic [9:0] d, input logic [10:0] n);
        wb_write(i, 3'd3, 64'd1, 8'hFF);
        wb_write(i, 3'd4, {54'd0, s}, 8'hFF);
        wb_write(i, 3'd5, {54'd0, d}, 8'hFF);
        wb_write(i, 3'd6, {53'd0, n}, 8'hFF);
        clear_mon(i);
    endtask

    task automatic push_copy(input logic [9:0] s, input logic [9:0] d, input int n);
        logic [9:0] sa, da;
        for (int k = 0; k < n; k++) begin
            sa = s + 10'(k);
            da = d + 10'(k);
            exp_rd_q.push_back(sa);
            exp_q.push_back({da, fdat(sa)});
        end
    endtask

    task automatic start(input int i, output int t);
        t = cyc;
        wb_write(i, 3'd1, 64'h3, 8'hFF);
    endtask

    task automatic wait_irq(input int i, input int budget, input string name);
        int n = 0;
        while (!irq[i] && n < budget) begin
            tick;
            n++;
        end
        check(name, irq[i], 1'b1);
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [63:0] wd;
        logic [7:0]  ws;
        logic [2:0]  ra;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, n, n0, r0;

        vt[0]  = '{1'b0, 3'd0, 64'd0,          8'h00, 3'd0, CORE};
        vt[1]  = '{1'b0, 3'd0, 64'd0,          8'h00, 3'd1, 64'd0};
        vt[2]  = '{1'b0, 3'd0, 64'd0,          8'h00, 3'd2, 64'd0};
        vt[3]  = '{1'b0, 3'd0, 64'd0,          8'h00, 3'd7, 64'd0};
        vt[4]  = '{1'b1, 3'd4, 64'h123,        8'hFF, 3'd4, 64'h123};
        vt[5]  = '{1'b1, 3'd4, 64'hFFFF_FFFF,  8'h01, 3'd4, 64'h1FF};
        vt[6]  = '{1'b1, 3'd4, 64'h0,          8'h02, 3'd4, 64'h0FF};
        vt[7]  = '{1'b1, 3'd5, 64'hFFFF_FFFF,  8'hFF, 3'd5, 64'h3FF};
        vt[8]  = '{1'b1, 3'd6, 64'hFFFF,       8'hFF, 3'd6, 64'h7FF};
        vt[9]  = '{1'b1, 3'd0, 64'h0,          8'hFF, 3'd0, CORE};
        vt[10] = '{1'b1, 3'd2, 64'h3,          8'hFF, 3'd2, 64'd0};
        vt[11] = '{1'b1, 3'd1, 64'h2,          8'hFF, 3'd1, 64'h2};
        vt[12] = '{1'b1, 3'd1, 64'h0,          8'h00, 3'd1, 64'h2};
        vt[13] = '{1'b1, 3'd7, 64'h5,          8'hFF, 3'd7, 64'd0};

        reset = 1'b1; adr = 8'd2; wdat = '0; sel = '0; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stb[i] = 1'b0; irq_q[i] = 1'b0;
            clear_mon(i);
        end
        repeat (3) tick;
        check("reset_outputs", {src_en[0], dst_we[0], irq[0], src_en[2], dst_we[2]}, 5'b0);
        reset = 1'b0;
        tick;

        for (int v = 0; v < 14; v++) begin
            if (vt[v].we) wb_write(0, vt[v].wa, vt[v].wd, vt[v].ws);
            wb_check(0, vt[v].ra, vt[v].exp, $sformatf("vec%0d", v));
        end

        // Basic 4-word copy, L = 2.
        setup(0, 10'h010, 10'h200, 11'd4);
        push_copy(10'h010, 10'h200, 4);
        start(0, t);
        wait_irq(0, 50, "t1_done");
        check("t1_first_we", first_we[0], t + 3);
        check("t1_last_we", last_we[0], t + 6);
        check("t1_done_cycle", irq_rise[0], t + 7);
        check("t1_nwe", nwe[0], 4);
        wb_check(0, 3'd2, 64'h2, "t1_status");
        wb_check(0, 3'd7, 64'd4, "t1_count");
        check("t1_sb_empty", {exp_q.size(), exp_rd_q.size()}, 64'd0);

        // LEN = 0: done next cycle, no SRAM access, never busy.
        setup(0, 10'h123, 10'h234, 11'd0);
        start(0, t);
        check("t2_done_next", irq_rise[0], t + 1);
        repeat (5) tick;
        check("t2_no_access", {nrd[0], nwe[0]}, 64'd0);
        check("t2_never_busy", busy_seen, 1'b0);
        wb_check(0, 3'd2, 64'h2, "t2_status");
        wb_check(0, 3'd7, 64'd0, "t2_count");

        // Address wrap at the top of memory.
        setup(0, 10'h3FE, 10'h3FF, 11'd3);
        push_copy(10'h3FE, 10'h3FF, 3);
        start(0, t);
        wait_irq(0, 50, "t3_done");
        check("t3_sb_empty", {exp_q.size(), exp_rd_q.size()}, 64'd0);
        check("t3_nwe", nwe[0], 3);
        wb_check(0, 3'd7, 64'd3, "t3_count");

        // DONE_CLR in the very cycle done is set: set wins.
        setup(0, 10'h050, 10'h150, 11'd1);
        push_copy(10'h050, 10'h150, 1);
        start(0, t);
        while (cyc < t + 3) tick;
        wb_write(0, 3'd3, 64'd1, 8'hFF);
        check("setwins_irq", irq[0], 1'b1);
        check("setwins_cycle", irq_rise[0], t + 4);
        wb_check(0, 3'd2, 64'h2, "setwins_status");

        // Writes and start while busy are ignored; irq follows done.
        setup(0, 10'h040, 10'h100, 11'd16);
        push_copy(10'h040, 10'h100, 16);
        start(0, t);
        repeat (3) tick;
        wb_write(0, 3'd6, 64'd1, 8'hFF);
        wb_write(0, 3'd4, 64'd0, 8'hFF);
        start(0, t2);
        wait_irq(0, 60, "t4_done");
        check("t4_nwe", nwe[0], 16);
        check("t4_last_we", last_we[0], t + 18);
        check("t4_done_cycle", irq_rise[0], t + 19);
        wb_check(0, 3'd7, 64'd16, "t4_count");
        wb_check(0, 3'd6, 64'd16, "t4_len_kept");
        wb_check(0, 3'd4, 64'h040, "t4_src_kept");
        check("t4_sb_empty", {exp_q.size(), exp_rd_q.size()}, 64'd0);
        wb_write(0, 3'd3, 64'd1, 8'hFF);
        check("t4_irq_clr", irq[0], 1'b0);
        wb_check(0, 3'd2, 64'h0, "t4_status_clr");

        // Completion timing at latencies 1 and 4.
        for (int i = 1; i < 3; i++) begin
            setup(i, 10'h020, 10'h300, 11'd8);
            start(i, t);
            wait_irq(i, 60, $sformatf("lat%0d_done", LAT[i]));
            check($sformatf("lat%0d_first_we", LAT[i]), first_we[i], t + 1 + LAT[i]);
            check($sformatf("lat%0d_last_we", LAT[i]), last_we[i], t + 8 + LAT[i]);
            check($sformatf("lat%0d_done_cycle", LAT[i]), irq_rise[i], t + 9 + LAT[i]);
            check($sformatf("lat%0d_nwe", LAT[i]), nwe[i], 8);
            wb_check(i, 3'd7, 64'd8, $sformatf("lat%0d_count", LAT[i]));
        end

        // Reset in the middle of a 16-word copy.
        setup(0, 10'h000, 10'h080, 11'd16);
        push_copy(10'h000, 10'h080, 16);
        start(0, t);
        n = 0;
        while (nwe[0] < 5 && n < 60) begin
            tick;
            n++;
        end
        check("t5_reached_word5", nwe[0], 5);
        check("t5_active_before", {src_en[0], dst_we[0]}, 2'b11);
        #1 reset = 1'b1;
        #1 check("t5_drop_on_reset", {src_en[0], dst_we[0]}, 2'b00);
        exp_q.delete();
        exp_rd_q.delete();
        tick;
        tick;
        reset = 1'b0;
        n0 = nwe[0];
        r0 = nrd[0];
        repeat (20) tick;
        check("t5_no_more_access", {nwe[0] - n0, nrd[0] - r0}, 64'd0);
        wb_check(0, 3'd2, 64'h0, "t5_status");
        wb_check(0, 3'd7, 64'd0, "t5_count");
        wb_check(0, 3'd6, 64'd0, "t5_len");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
